// File: rtl/pow2_accum.sv
// pow2_accum: saturating sum of els_p pow2 results over valid/yumi, presented with a sticky overflow flag.
// Define POW2_ACCUM_OVERLAP_EN to accept the next group's first datum while the finished sum drains.
module pow2_accum #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               ovf_o,
  output logic [7:0]         cnt_o,
  input  logic               yumi_i
);
  typedef enum logic {ACCUM, DONE} state_e;
  localparam logic [7:0] last_lp = 8'(els_p - 1);
  state_e             r_state, w_state_n;
  logic [width_p-1:0] r_sum, w_sum_n;
  logic [7:0]         r_cnt, w_cnt_n;
  logic               r_ovf, w_ovf_n;
  logic [width_p:0]   w_add;
  logic               w_done_take;
  assign w_add = {1'b0, r_sum} + {1'b0, data_i};
`ifdef POW2_ACCUM_OVERLAP_EN
  assign w_done_take = v_i & yumi_i;
`else
  assign w_done_take = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_state <= ACCUM;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sum   <= w_sum_n;
      r_cnt   <= w_cnt_n;
      r_ovf   <= w_ovf_n;
    end
  always_comb begin
    w_state_n = r_state;
    w_sum_n   = r_sum;
    w_cnt_n   = r_cnt;
    w_ovf_n   = r_ovf;
    if (r_state == ACCUM) begin
      if (v_i) begin
        w_sum_n = w_add[width_p] ? '1 : w_add[width_p-1:0];
        w_ovf_n = r_ovf | w_add[width_p];
        w_cnt_n = r_cnt + 8'd1;
        w_state_n = (r_cnt == last_lp) ? DONE : ACCUM;
      end
    end else if (yumi_i) begin
      // A datum taken alongside the drain seeds the next group
      w_sum_n   = w_done_take ? data_i : '0;
      w_cnt_n   = {7'd0, w_done_take};
      w_ovf_n   = 1'b0;
      w_state_n = ACCUM;
    end
  end
  assign v_o    = (r_state == DONE);
  assign data_o = v_o ? r_sum : '0;
  assign ovf_o  = v_o & r_ovf;
  assign cnt_o  = r_cnt;
  assign yumi_o = reset_n_i & (v_o ? w_done_take : v_i);
endmodule

// File: tb/tb_pow2_accum.sv
// tb_pow2_accum: randomized and directed checks of pow2_accum against a group-sum reference model.
module tb_pow2_accum;
  localparam int ELS = 4;
  localparam logic [32:0] MAXV = 33'h0_FFFF_FFFF;
`ifdef POW2_ACCUM_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif
  logic        clk = 1'b0, reset_n_i = 1'b0, v_i = 1'b0, yumi_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        yumi_o, v_o, ovf_o;
  logic [31:0] data_o;
  logic [7:0]  cnt_o;
  int          n_cmp = 0, n_bad = 0, mode = 0, cyc = 0;
  bit          m_pend, m_ovf, m_acc;
  int          m_cnt;
  logic [32:0] m_sum, t;

  pow2_accum #(.width_p(32), .els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .ovf_o(ovf_o), .cnt_o(cnt_o), .yumi_i(yumi_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Consumer: mode 0 never takes, 1 takes immediately, 2 takes after a random delay
  always @(posedge clk) begin
    #1;
    yumi_i = v_o && (mode == 1 || (mode == 2 && $urandom_range(2, 0) == 0));
  end

  // Reference model: outputs checked, then next state computed from the inputs about to be sampled
  always @(negedge clk) begin
    if (!reset_n_i) begin
      chk("rst_v_o", v_o, 0);
      chk("rst_cnt_o", cnt_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_yumi_o", yumi_o, 0);
      m_pend = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
    end else begin
      m_acc = v_i && (!m_pend || (OV && yumi_i));
      chk("v_o", v_o, m_pend);
      chk("yumi_o", yumi_o, m_acc);
      chk("cnt_o", cnt_o, m_cnt);
      chk("yumi_protocol", yumi_i & ~v_o, 0);
      if (m_pend) begin
        chk("data_o", data_o, m_sum[31:0]);
        chk("ovf_o", ovf_o, m_ovf);
      end
      if (m_pend && yumi_i) begin
        m_pend = 0; m_cnt = 0; m_sum = 0; m_ovf = 0;
      end
      if (m_acc) begin
        t = m_sum + {1'b0, data_i};
        if (t > MAXV) begin
          m_sum = MAXV; m_ovf = 1;
        end else m_sum = t;
        m_cnt++;
        if (m_cnt == ELS) m_pend = 1;
      end
    end
  end

  task automatic push(input logic [31:0] d);
    logic acc;
    acc = 0;
    v_i = 1; data_i = d;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = yumi_o;
      @(posedge clk); #1;
    end
    if (!acc) chk("push_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    v_i = 0;
    data_i = $urandom;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_vo();
    for (int k = 0; k < 200 && !v_o; k++) begin @(posedge clk); #1; end
    chk("wait_vo_timeout", v_o, 1);
  endtask

  task automatic drain();
    v_i = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_dat();
    int r;
    r = $urandom_range(9, 0);
    return r == 0 ? 32'h0 : r == 1 ? 32'($urandom) : r == 2 ? 32'h8000_0000 : 32'h1 << $urandom_range(31, 0);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1;
    mode = 1;
    push(1); push(2); push(4); push(8);
    v_i = 0;
    wait_vo();
    chk("g1_sum", data_o, 15);
    chk("g1_ovf", ovf_o, 0);
    drain();
    chk("g1_cnt_after", cnt_o, 0);
    push(32'h8000_0000); push(32'h8000_0000); push(1); push(2);
    v_i = 0;
    wait_vo();
    chk("sat_sum", data_o, 32'hFFFF_FFFF);
    chk("sat_ovf", ovf_o, 1);
    drain();
    push(1); push(1); push(1); push(1);
    v_i = 0;
    wait_vo();
    chk("g3_sum", data_o, 4);
    chk("g3_ovf", ovf_o, 0);
    drain();
    mode = 0;
    push(1); push(2); push(4); push(8);
    data_i = 32'h40;
    repeat (10) begin
      chk("hold_data", data_o, 15);
      chk("hold_yumi", yumi_o, 0);
      @(posedge clk); #1;
    end
    mode = 1;
    repeat (4) push(32'h40);
    v_i = 0;
    wait_vo();
    chk("after_hold_sum", data_o, 32'h100);
    drain();
    push(1); push(2);
    v_i = 0;
    chk("mid_cnt", cnt_o, 2);
    reset_n_i = 0;
    #1;
    chk("async_v_o", v_o, 0);
    chk("async_data_o", data_o, 0);
    chk("async_cnt_o", cnt_o, 0);
    @(posedge clk); #1 reset_n_i = 1;
    repeat (4) push(16);
    v_i = 0;
    wait_vo();
    chk("post_rst_sum", data_o, 64);
    drain();
    if (OV) begin
      c0 = cyc;
      for (int i = 0; i < 8; i++) push(32'h1 << i);
      chk("ovl_cycles", cyc - c0, 8);
      v_i = 0;
      wait_vo();
      chk("ovl_sum2", data_o, 240);
      drain();
    end
    mode = 2;
    for (int g = 0; g < 100; g++)
      for (int i = 0; i < ELS; i++) begin
        idle($urandom_range(1, 0));
        push(rnd_dat());
      end
    idle(1);
    mode = 1;
    idle(20);
    chk("final_idle_v_o", v_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pow2_accum.md
Name: pow2_accum

Overview:
- Downstream consumer of the pow2 stage. It accepts a stream of 32-bit power-of-two results over a valid/yumi interface.
- It sums each group of els_p consecutive results with unsigned saturation. It then presents the group sum and a sticky overflow flag on its own valid/yumi output toward the trace/consumer side.
- Its input handshake mirrors pow2's output: pow2 drives v_o/data_o and this block drives the yumi back.

Parameters:
- width_p, 32, width of input data and of the output sum.
- els_p, 4, results summed per group; legal range 2..255.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  input datum valid (from pow2 v_o).
- data_i  in  width_p  input datum (from pow2 data_o).
- yumi_o  out  1  input datum consumed this cycle (to pow2 yumi_i).
- v_o  out  1  group sum valid.
- data_o  out  width_p  saturated group sum.
- ovf_o  out  1  sum saturated at least once in this group.
- cnt_o  out  8  number of results accepted into the current group (debug).
- yumi_i  in  1  consumer takes data_o/ovf_o; legal only while v_o=1.

Behaviour:
- Reset (async assert on reset_n_i=0, sync release):
  - state=ACCUM; sum, cnt and ovf are 0.
  - Outputs: v_o=0, data_o=0, ovf_o=0, cnt_o=0, yumi_o=0.
  - Reset asserted mid-group discards the partial sum and any pending output.
- States: ACCUM and DONE.
- ACCUM:
  - yumi_o = v_i (combinational; there is no registered ready).
  - On v_i=1:
    - If sum+data_i carries out of width_p bits: sum := all-ones and ovf := 1. Otherwise sum := sum+data_i.
    - cnt := cnt+1.
    - If cnt == els_p-1 before the increment: go to DONE.
  - v_o=0.
- DONE:
  - v_o=1; data_o=sum; ovf_o=ovf; cnt_o=els_p; yumi_o=0 (without the optional feature).
  - On yumi_i=1: sum, cnt and ovf are 0; return to ACCUM.
  - data_o, ovf_o and v_o hold stable until yumi_i.
- Latency: v_o rises on the clock edge that accepts the els_p-th input, i.e. visible the cycle after that input is consumed.
- Saturation:
  - Once sum is all-ones it remains all-ones for the rest of the group.
  - ovf is sticky within the group.
  - Adding 0 never sets ovf.
- data_i is ignored when v_i=0. yumi_i while v_o=0 is ignored; a bench assertion flags it.
- Throughput without the optional feature: at most els_p inputs per els_p+1 cycles (one bubble for the output handshake).

Optional Feature:
- Macro POW2_ACCUM_OVERLAP_EN.
- When defined:
  - In DONE, yumi_o = v_i & yumi_i.
  - A datum accepted in the same cycle as yumi_i becomes the first element of the next group: sum := data_i, ovf := 0, cnt := 1, state := ACCUM.
  - This gives full throughput of one input per cycle.
- When undefined: yumi_o=0 in DONE, and one bubble per group as above.
- The port list is identical in both builds.

Test Plan:
- Reset, then feed 1,2,4,8 back-to-back with yumi_i held at 1 -> yumi_o high 4 cycles; v_o=1 one cycle later with data_o=15 and ovf_o=0; after yumi_i, cnt_o=0.
- Feed 0x80000000, 0x80000000, 0x1, 0x2 -> data_o=0xFFFFFFFF, ovf_o=1; next group of 1,1,1,1 gives data_o=4, ovf_o=0.
- Hold yumi_i=0 for 10 cycles after v_o rises while v_i stays 1 -> data_o stable; yumi_o=0 throughout (overlap off); no input lost once yumi_i pulses.
- Assert reset_n_i low after 2 of 4 inputs (sum=3) -> v_o, data_o and cnt_o go 0 immediately; a subsequent group of 16,16,16,16 gives data_o=64.
- Random v_i gaps (50% duty) over 100 groups of els_p=4 against a reference-model sum, with random yumi_i delays -> every data_o/ovf_o matches the model.
- With POW2_ACCUM_OVERLAP_EN, stream 8 values continuously with yumi_i=1 -> two sums emitted, and yumi_o never drops while v_i=1.
